// File: rtl/ghost_dir_ctrl.sv
// ghost_dir_ctrl: per-frame direction decision for one ghost.
//
// Runs the SCATTER / CHASE / FRIGHT behaviour-mode machine on frame timers.
// Tracks which axis the ghost is travelling on. Once per frame it produces a
// preferred turn sign toward the current target, for the movement block
// downstream.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   startOfFrame  in   one-clock pulse per frame
//   ghostX/ghostY in   ghost top-left position (signed pixels)
//   pacX/pacY     in   Pac-Man top-left position (signed pixels)
//   power_pellet  in   one-clock pulse, Pac-Man ate a power pellet
//   rnd_dir       out  bit0 turn sign (1 = +axis), bit1 = |dy| > |dx|
//   mode          out  00 SCATTER, 01 CHASE, 10 FRIGHT
//   frightened    out  high while in FRIGHT
//   fright_ending out  high in FRIGHT once remaining frames <= FRIGHT_WARN
module ghost_dir_ctrl #(
    parameter int unsigned SCATTER_FRAMES = 210,
    parameter int unsigned CHASE_FRAMES   = 600,
    parameter int unsigned FRIGHT_FRAMES  = 180,
    parameter int unsigned FRIGHT_WARN    = 60,
    parameter int          SCATTER_X      = 600,
    parameter int          SCATTER_Y      = 20,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic signed [10:0] ghostX,
    input  logic signed [10:0] ghostY,
    input  logic signed [10:0] pacX,
    input  logic signed [10:0] pacY,
    input  logic               power_pellet,
    output logic [1:0]         rnd_dir,
    output logic [1:0]         mode,
    output logic               frightened,
    output logic               fright_ending
);

    localparam int unsigned CntW = 16;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LfsrTaps = 16'hB400;

    typedef enum logic [1:0] {
        ModeScatter = 2'b00,
        ModeChase   = 2'b01,
        ModeFright  = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        PipeIdle = 2'b00,
        PipeD2   = 2'b01,
        PipeD3   = 2'b10
    } pipe_e;

    // Mode machine state
    mode_e            mode_q, mode_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             frightened_q, frightened_d;
    logic             fright_ending_q, fright_ending_d;
    logic [31:0]      fright_left;

    // LFSR
    logic [15:0]      lfsr_q, lfsr_d;

    // Decision pipeline
    pipe_e              pipe_q, pipe_d;
    logic signed [10:0] gx_q, gx_d, gy_q, gy_d;
    logic signed [10:0] tx_q, tx_d, ty_q, ty_d;
    logic signed [10:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic               moving_x_q, moving_x_d;
    logic               dec_fright_q, dec_fright_d;
    logic [11:0]        dx_q, dx_d, dy_q, dy_d;
    logic [11:0]        adx_q, adx_d, ady_q, ady_d;
    logic [1:0]         rnd_dir_q, rnd_dir_d;

    logic [11:0]        dx_w, dy_w, sel_w;

    // ------------------------------------------------------------------
    // Mode machine. A pellet overrides the frame tick in the same clock.
    // ------------------------------------------------------------------
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (power_pellet) begin
            mode_d = ModeFright;
            cnt_d  = '0;
        end else if (startOfFrame) begin
            unique case (mode_q)
                ModeScatter: begin
                    if (cnt_q == CntW'(SCATTER_FRAMES - 1)) begin
                        mode_d = ModeChase;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ModeChase: begin
                    if (cnt_q == CntW'(CHASE_FRAMES - 1)) begin
                        mode_d = ModeScatter;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ModeFright: begin
                    if (cnt_q == CntW'(FRIGHT_FRAMES - 1)) begin
                        mode_d = ModeChase;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    mode_d = ModeScatter;
                    cnt_d  = '0;
                end
            endcase
        end
    end

    // Counter never exceeds FRIGHT_FRAMES-1 while in FRIGHT, so no underflow.
    assign fright_left     = FRIGHT_FRAMES - 32'd1 - 32'(cnt_d);
    assign frightened_d    = (mode_d == ModeFright);
    assign fright_ending_d = frightened_d && (fright_left <= FRIGHT_WARN);

    // ------------------------------------------------------------------
    // LFSR: free-running, self-recovers from the all-zero lock-up state.
    // ------------------------------------------------------------------
    always_comb begin
        if (lfsr_q == 16'h0000) begin
            lfsr_d = LFSR_SEED;
        end else begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0000);
        end
    end

    // ------------------------------------------------------------------
    // Decision pipeline: D1 latch, D2 differences, D3 register rnd_dir.
    // ------------------------------------------------------------------
    // Sign-extend to 12 bits; the difference of two 11-bit values cannot overflow.
    assign dx_w  = {tx_q[10], tx_q} - {gx_q[10], gx_q};
    assign dy_w  = {ty_q[10], ty_q} - {gy_q[10], gy_q};
    assign sel_w = moving_x_q ? dy_q : dx_q;

    always_comb begin
        pipe_d       = pipe_q;
        gx_d         = gx_q;
        gy_d         = gy_q;
        tx_d         = tx_q;
        ty_d         = ty_q;
        prev_x_d     = prev_x_q;
        prev_y_d     = prev_y_q;
        moving_x_d   = moving_x_q;
        dec_fright_d = dec_fright_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        adx_d        = adx_q;
        ady_d        = ady_q;
        rnd_dir_d    = rnd_dir_q;

        unique case (pipe_q)
            PipeIdle: begin
                if (startOfFrame) begin
                    pipe_d       = PipeD2;
                    gx_d         = ghostX;
                    gy_d         = ghostY;
                    dec_fright_d = (mode_q == ModeFright);
                    if (mode_q == ModeScatter) begin
                        tx_d = 11'(SCATTER_X);
                        ty_d = 11'(SCATTER_Y);
                    end else if (mode_q == ModeChase) begin
                        tx_d = pacX;
                        ty_d = pacY;
                    end
                    // Axis inference: X motion wins; no motion keeps the last axis.
                    if (ghostX != prev_x_q) begin
                        moving_x_d = 1'b1;
                    end else if (ghostY != prev_y_q) begin
                        moving_x_d = 1'b0;
                    end
                    prev_x_d = ghostX;
                    prev_y_d = ghostY;
                end
            end
            PipeD2: begin
                pipe_d = PipeD3;
                dx_d   = dx_w;
                dy_d   = dy_w;
                adx_d  = dx_w[11] ? (~dx_w + 12'd1) : dx_w;
                ady_d  = dy_w[11] ? (~dy_w + 12'd1) : dy_w;
            end
            PipeD3: begin
                pipe_d = PipeIdle;
                if (dec_fright_q) begin
                    rnd_dir_d = lfsr_q[1:0];
                end else begin
                    // Turn sign follows the axis perpendicular to travel; ties go random.
                    rnd_dir_d[0] = (sel_w == 12'd0) ? lfsr_q[0] : ~sel_w[11];
                    rnd_dir_d[1] = (ady_q > adx_q);
                end
            end
            default: begin
                pipe_d = PipeIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q          <= ModeScatter;
            cnt_q           <= '0;
            frightened_q    <= 1'b0;
            fright_ending_q <= 1'b0;
            lfsr_q          <= LFSR_SEED;
            pipe_q          <= PipeIdle;
            gx_q            <= '0;
            gy_q            <= '0;
            tx_q            <= '0;
            ty_q            <= '0;
            prev_x_q        <= ghostX;
            prev_y_q        <= ghostY;
            moving_x_q      <= 1'b1;
            dec_fright_q    <= 1'b0;
            dx_q            <= '0;
            dy_q            <= '0;
            adx_q           <= '0;
            ady_q           <= '0;
            rnd_dir_q       <= 2'b01;
        end else begin
            mode_q          <= mode_d;
            cnt_q           <= cnt_d;
            frightened_q    <= frightened_d;
            fright_ending_q <= fright_ending_d;
            lfsr_q          <= lfsr_d;
            pipe_q          <= pipe_d;
            gx_q            <= gx_d;
            gy_q            <= gy_d;
            tx_q            <= tx_d;
            ty_q            <= ty_d;
            prev_x_q        <= prev_x_d;
            prev_y_q        <= prev_y_d;
            moving_x_q      <= moving_x_d;
            dec_fright_q    <= dec_fright_d;
            dx_q            <= dx_d;
            dy_q            <= dy_d;
            adx_q           <= adx_d;
            ady_q           <= ady_d;
            rnd_dir_q       <= rnd_dir_d;
        end
    end

    assign rnd_dir       = rnd_dir_q;
    assign mode          = mode_q;
    assign frightened    = frightened_q;
    assign fright_ending = fright_ending_q;

endmodule
